// File: rtl/spu_pipe_pkg.sv
// Shared types for the SPU result pipeline.
// One pipe entry carries an execute result from EX towards write-back.
package spu_pipe_pkg;

  localparam int REG_AW = 7;
  localparam int UNIT_W = 3;
  localparam int LAT_W  = 3;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [REG_AW-1:0] rt;
    logic [UNIT_W-1:0] unit;
    logic [LAT_W-1:0]  lat;
    logic [DATA_W-1:0] data;
  } pipe_entry_t;

  // A zero latency means ready at stage 1; anything past the end is ready at WB.
  function automatic logic [LAT_W-1:0] lat_clamp(
    input logic [LAT_W-1:0] lat,
    input int unsigned      depth
  );
    if (lat == '0) return LAT_W'(1);
    if (32'(lat) > depth) return LAT_W'(depth);
    return lat;
  endfunction

endpackage

// File: rtl/result_pipe_stage.sv
// One LANES-wide row of result-pipe registers.
// A clear drops valid/we of the incoming row instead of shifting it in.
module result_pipe_stage
  import spu_pipe_pkg::*;
#(
  parameter int LANES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  pipe_entry_t [LANES-1:0] d_i,
  output pipe_entry_t [LANES-1:0] q_o
);

  pipe_entry_t [LANES-1:0] row_q;
  pipe_entry_t [LANES-1:0] row_d;

  always_comb begin
    row_d = d_i;
    if (clr_i) begin
      for (int l = 0; l < LANES; l++) begin
        row_d[l].valid = 1'b0;
        row_d[l].we    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) row_q <= '0;
    else       row_q <= row_d;
  end

  assign q_o = row_q;

endmodule

// File: rtl/result_pipe.sv
// Multi-lane EX-to-WB result pipeline with flush,
// latency-aware forwarding and same-cycle WAW squash at write-back.
module result_pipe #(
  parameter int LANES        = 2,
  parameter int DEPTH        = 7,
  parameter int DATA_W       = 128,
  parameter int REG_AW       = 7,
  parameter int UNIT_W       = 3,
  parameter int LAT_W        = 3,
  parameter int NQ           = 6,
  parameter int FLUSH_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [LANES-1:0]         iss_valid,
  input  logic [LANES-1:0]         iss_we,
  input  logic [LANES*REG_AW-1:0]  iss_rt,
  input  logic [LANES*UNIT_W-1:0]  iss_unit,
  input  logic [LANES*LAT_W-1:0]   iss_lat,
  input  logic [LANES*DATA_W-1:0]  iss_data,
  input  logic [NQ*REG_AW-1:0]     q_addr,
  output logic [NQ-1:0]            q_hit,
  output logic [NQ-1:0]            q_stall,
  output logic [NQ*DATA_W-1:0]     q_data,
  output logic [LANES-1:0]         wb_valid,
  output logic [LANES-1:0]         wb_we,
  output logic [LANES*REG_AW-1:0]  wb_rt,
  output logic [LANES*UNIT_W-1:0]  wb_unit,
  output logic [LANES*DATA_W-1:0]  wb_data
);

  import spu_pipe_pkg::*;

  pipe_entry_t [LANES-1:0] iss_row;
  pipe_entry_t [LANES-1:0] st [1:DEPTH];

  always_comb begin
    iss_row = '0;
    for (int l = 0; l < LANES; l++) begin
      iss_row[l].valid = iss_valid[l];
      iss_row[l].we    = iss_valid[l] & iss_we[l];
      iss_row[l].rt    = iss_rt[l*REG_AW +: REG_AW];
      iss_row[l].unit  = iss_unit[l*UNIT_W +: UNIT_W];
      iss_row[l].lat   = lat_clamp(iss_lat[l*LAT_W +: LAT_W], DEPTH);
      iss_row[l].data  = iss_data[l*DATA_W +: DATA_W];
    end
  end

  // Stage FLUSH_STAGES+1 is cleared too because its source row is squashed.
  for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
    localparam bit CLR = (s <= FLUSH_STAGES + 1);
    result_pipe_stage #(.LANES(LANES)) u_stage (
      .clk   (clk),
      .reset (reset),
      .clr_i (CLR ? flush : 1'b0),
      .d_i   ((s == 1) ? iss_row : st[(s == 1) ? 1 : s-1]),
      .q_o   (st[s])
    );
  end

  logic              fw_found;
  logic              fw_rdy;
  logic [DATA_W-1:0] fw_data;

  always_comb begin
    q_hit    = '0;
    q_stall  = '0;
    q_data   = '0;
    fw_found = 1'b0;
    fw_rdy   = 1'b0;
    fw_data  = '0;
    for (int q = 0; q < NQ; q++) begin
      fw_found = 1'b0;
      fw_rdy   = 1'b0;
      fw_data  = '0;
      // Oldest first so the youngest candidate overwrites the result.
      for (int s = DEPTH; s >= 1; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (st[s][l].valid && st[s][l].we &&
              st[s][l].rt == q_addr[q*REG_AW +: REG_AW]) begin
            fw_found = 1'b1;
            fw_rdy   = (s >= int'(st[s][l].lat));
            fw_data  = st[s][l].data;
          end
        end
      end
      q_hit[q]   = fw_found & fw_rdy;
      q_stall[q] = fw_found & ~fw_rdy;
      if (fw_found && fw_rdy) q_data[q*DATA_W +: DATA_W] = fw_data;
    end
  end

  logic waw_sq;

  always_comb begin
    wb_valid = '0;
    wb_we    = '0;
    wb_rt    = '0;
    wb_unit  = '0;
    wb_data  = '0;
    waw_sq   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      waw_sq = 1'b0;
      for (int j = l + 1; j < LANES; j++) begin
        if (st[DEPTH][j].valid && st[DEPTH][j].we &&
            st[DEPTH][j].rt == st[DEPTH][l].rt)
          waw_sq = 1'b1;
      end
      wb_valid[l] = st[DEPTH][l].valid;
      wb_we[l]    = st[DEPTH][l].valid & st[DEPTH][l].we & ~waw_sq;
      wb_rt[l*REG_AW +: REG_AW]   = st[DEPTH][l].rt;
      wb_unit[l*UNIT_W +: UNIT_W] = st[DEPTH][l].unit;
      wb_data[l*DATA_W +: DATA_W] = st[DEPTH][l].data;
    end
  end

endmodule

// File: tb/tb_result_pipe.sv
// Directed bench for result_pipe: a 2-lane/7-deep instance
// and a 3-lane/4-deep instance driven in turn.
module tb_result_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int cmps = 0;
  int fails = 0;

  localparam logic [127:0] AA = {16{8'hAA}};

  logic [1:0]   a_v, a_we, a_hv, a_wbv, a_wbwe;
  logic [13:0]  a_rt, a_wbrt;
  logic [5:0]   a_unit, a_lat, a_hit, a_stall, a_wbu;
  logic [255:0] a_data, a_wbd;
  logic [41:0]  a_qa;
  logic [767:0] a_qd;

  logic [2:0]   b_v, b_we, b_wbv, b_wbwe;
  logic [20:0]  b_rt, b_wbrt;
  logic [8:0]   b_unit, b_lat, b_wbu;
  logic [383:0] b_data, b_wbd;
  logic [41:0]  b_qa;
  logic [5:0]   b_hit, b_stall;
  logic [767:0] b_qd;

  assign a_hv = '0;

  result_pipe u_a (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_valid(a_v), .iss_we(a_we), .iss_rt(a_rt),
    .iss_unit(a_unit), .iss_lat(a_lat), .iss_data(a_data),
    .q_addr(a_qa), .q_hit(a_hit), .q_stall(a_stall),
    .q_data(a_qd), .wb_valid(a_wbv), .wb_we(a_wbwe),
    .wb_rt(a_wbrt), .wb_unit(a_wbu), .wb_data(a_wbd)
  );

  result_pipe #(.LANES(3), .DEPTH(4), .FLUSH_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .flush(flush),
    .iss_valid(b_v), .iss_we(b_we), .iss_rt(b_rt),
    .iss_unit(b_unit), .iss_lat(b_lat), .iss_data(b_data),
    .q_addr(b_qa), .q_hit(b_hit), .q_stall(b_stall),
    .q_data(b_qd), .wb_valid(b_wbv), .wb_we(b_wbwe),
    .wb_rt(b_wbrt), .wb_unit(b_wbu), .wb_data(b_wbd)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    cmps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_clr();
    a_v = '0; a_we = '0; a_rt = '0;
    a_unit = '0; a_lat = '0; a_data = '0;
  endtask

  task automatic a_iss(input int l, input logic [6:0] rt,
                       input logic [2:0] lat, input logic [127:0] d);
    a_v[l] = 1'b1;
    a_we[l] = 1'b1;
    a_rt[l*7 +: 7] = rt;
    a_unit[l*3 +: 3] = 3'(l + 1);
    a_lat[l*3 +: 3] = lat;
    a_data[l*128 +: 128] = d;
  endtask

  task automatic b_clr();
    b_v = '0; b_we = '0; b_rt = '0;
    b_unit = '0; b_lat = '0; b_data = '0;
  endtask

  task automatic b_iss(input int l, input logic [6:0] rt,
                       input logic [2:0] lat, input logic [127:0] d);
    b_v[l] = 1'b1;
    b_we[l] = 1'b1;
    b_rt[l*7 +: 7] = rt;
    b_unit[l*3 +: 3] = 3'(l + 1);
    b_lat[l*3 +: 3] = lat;
    b_data[l*128 +: 128] = d;
  endtask

  initial begin
    a_clr(); b_clr();
    a_qa = '0; b_qa = '0;

    // Reset state
    tick();
    chk("rst a wb_valid", a_wbv, 0);
    chk("rst a wb_we", a_wbwe, 0);
    chk("rst a q_hit", a_hit, 0);
    chk("rst a q_stall", a_stall, 0);
    chk("rst a q_data", a_qd[127:0], 0);
    chk("rst b wb_valid", b_wbv, 0);
    reset = 1'b0;
    tick();

    // A T2: latency and data
    a_qa[6:0] = 7'd5;
    a_iss(0, 7'd5, 3'd2, AA);
    tick(); a_clr();
    chk("a t2 stall s1", a_stall[0], 1);
    chk("a t2 hit s1", a_hit[0], 0);
    tick();
    chk("a t2 hit s2", a_hit[0], 1);
    chk("a t2 data s2", a_qd[127:0], AA);
    tick(4);
    chk("a t2 wbv s6", a_wbv, 0);
    tick();
    chk("a t2 wb_we", a_wbwe, 2'b01);
    chk("a t2 wb_rt", a_wbrt[6:0], 5);
    chk("a t2 wb_unit", a_wbu[2:0], 1);
    chk("a t2 wb_data", a_wbd[127:0], AA);
    tick();

    // A T3: youngest wins
    a_qa[6:0] = 7'd9;
    a_iss(0, 7'd9, 3'd1, 128'd1);
    tick(); a_clr();
    a_iss(1, 7'd9, 3'd4, 128'd2);
    tick(); a_clr();
    chk("a t3 stall c2", a_stall[0], 1);
    chk("a t3 hit c2", a_hit[0], 0);
    chk("a t3 data c2", a_qd[127:0], 0);
    tick(3);
    chk("a t3 hit c5", a_hit[0], 1);
    chk("a t3 data c5", a_qd[127:0], 2);
    tick(2);
    chk("a t3 wb_we c7", a_wbwe, 2'b01);
    tick();
    chk("a t3 wb_we c8", a_wbwe, 2'b10);
    chk("a t3 wb_data c8", a_wbd[255:128], 2);
    tick();

    // A T4: same-stage priority and WAW squash
    a_qa[6:0] = 7'd3;
    a_iss(0, 7'd3, 3'd1, 128'h10);
    a_iss(1, 7'd3, 3'd1, 128'h20);
    tick(); a_clr();
    chk("a t4 hit", a_hit[0], 1);
    chk("a t4 data", a_qd[127:0], 128'h20);
    tick(6);
    chk("a t4 wb_valid", a_wbv, 2'b11);
    chk("a t4 wb_we", a_wbwe, 2'b10);
    tick();

    // A T5: flush with stages 1..3 occupied plus an issue
    a_qa = {7'd0, 7'd0, 7'd14, 7'd13, 7'd12, 7'd11};
    a_iss(0, 7'd11, 3'd1, 128'h11);
    tick(); a_clr();
    a_iss(0, 7'd12, 3'd1, 128'h12);
    tick(); a_clr();
    a_iss(0, 7'd13, 3'd1, 128'h13);
    tick(); a_clr();
    a_iss(0, 7'd14, 3'd1, 128'h14);
    flush = 1'b1;
    tick(); a_clr();
    flush = 1'b0;
    chk("a t5 hits", a_hit[3:0], 4'b0001);
    chk("a t5 stalls", a_stall[3:0], 0);
    chk("a t5 data", a_qd[127:0], 128'h11);
    tick(3);
    chk("a t5 wb_valid", a_wbv, 2'b01);
    chk("a t5 wb_rt", a_wbrt[6:0], 11);
    tick();
    chk("a t5 wbv after", a_wbv, 0);
    tick(2);
    chk("a t5 wbv late", a_wbv, 0);
    tick();

    // A T6: lat=0 ready at stage 1
    a_qa = '0;
    a_qa[6:0] = 7'd30;
    a_iss(0, 7'd30, 3'd0, 128'h30);
    tick(); a_clr();
    chk("a t6 hit s1", a_hit[0], 1);
    chk("a t6 data s1", a_qd[127:0], 128'h30);
    tick(7);

    // A T1: asynchronous reset mid-flight
    a_qa[6:0] = 7'd22;
    a_iss(0, 7'd20, 3'd1, 128'h20);
    a_iss(1, 7'd21, 3'd1, 128'h21);
    tick(); a_clr();
    a_iss(0, 7'd22, 3'd7, 128'h22);
    tick(); a_clr();
    tick(5);
    chk("a t1 wbv pre", a_wbv, 2'b11);
    chk("a t1 stall pre", a_stall[0], 1);
    #2 reset = 1'b1;
    #1;
    chk("a t1 wbv rst", a_wbv, a_hv);
    chk("a t1 stall rst", a_stall[0], 0);
    chk("a t1 hit rst", a_hit[0], 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("a t1 wbv post", a_wbv, 0);
    chk("a t1 stall post", a_stall[0], 0);

    // B T2
    b_qa[6:0] = 7'd5;
    b_iss(0, 7'd5, 3'd2, AA);
    tick(); b_clr();
    chk("b t2 stall s1", b_stall[0], 1);
    tick();
    chk("b t2 hit s2", b_hit[0], 1);
    chk("b t2 data s2", b_qd[127:0], AA);
    tick(2);
    chk("b t2 wb_we", b_wbwe, 3'b001);
    chk("b t2 wb_rt", b_wbrt[6:0], 5);
    tick();

    // B T3
    b_qa[6:0] = 7'd9;
    b_iss(0, 7'd9, 3'd1, 128'd1);
    tick(); b_clr();
    b_iss(1, 7'd9, 3'd4, 128'd2);
    tick(); b_clr();
    chk("b t3 stall c2", b_stall[0], 1);
    chk("b t3 data c2", b_qd[127:0], 0);
    tick(3);
    chk("b t3 hit c5", b_hit[0], 1);
    chk("b t3 data c5", b_qd[127:0], 2);
    tick();

    // B T4: three lanes, same rt
    b_qa[6:0] = 7'd3;
    b_iss(0, 7'd3, 3'd1, 128'h10);
    b_iss(1, 7'd3, 3'd1, 128'h20);
    b_iss(2, 7'd3, 3'd1, 128'h30);
    tick(); b_clr();
    chk("b t4 data", b_qd[127:0], 128'h30);
    tick(3);
    chk("b t4 wb_valid", b_wbv, 3'b111);
    chk("b t4 wb_we", b_wbwe, 3'b100);
    tick();

    // B T4b: only lanes 0 and 1 collide
    b_iss(0, 7'd3, 3'd1, 128'h10);
    b_iss(1, 7'd3, 3'd1, 128'h20);
    b_iss(2, 7'd4, 3'd1, 128'h30);
    tick(); b_clr();
    tick(3);
    chk("b t4b wb_we", b_wbwe, 3'b110);
    tick();

    // B T5: flush
    b_qa = {7'd0, 7'd0, 7'd14, 7'd13, 7'd12, 7'd11};
    b_iss(0, 7'd11, 3'd1, 128'h11);
    tick(); b_clr();
    b_iss(0, 7'd12, 3'd1, 128'h12);
    tick(); b_clr();
    b_iss(0, 7'd13, 3'd1, 128'h13);
    tick(); b_clr();
    b_iss(0, 7'd14, 3'd1, 128'h14);
    flush = 1'b1;
    tick(); b_clr();
    flush = 1'b0;
    chk("b t5 wb_valid", b_wbv, 3'b001);
    chk("b t5 wb_rt", b_wbrt[6:0], 11);
    chk("b t5 hits", b_hit[3:0], 4'b0001);
    chk("b t5 stalls", b_stall[3:0], 0);
    tick();
    chk("b t5 wbv after", b_wbv, 0);
    tick(2);

    // B T6: lat=7 clamps to DEPTH=4
    b_qa = '0;
    b_qa[6:0] = 7'd40;
    b_iss(0, 7'd40, 3'd7, 128'h40);
    tick(); b_clr();
    chk("b t6 stall s1", b_stall[0], 1);
    tick(2);
    chk("b t6 stall s3", b_stall[0], 1);
    chk("b t6 hit s3", b_hit[0], 0);
    tick();
    chk("b t6 hit s4", b_hit[0], 1);
    chk("b t6 data s4", b_qd[127:0], 128'h40);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmps, fails);
    $finish;
  end

endmodule
